// File: rtl/fetch_buffer_pkg.sv
// Shared types for the F2-to-decode fetch buffer: the fetch entry record,
// the default queue depth and a small count-clamping helper.
package fetch_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pre_b;
        logic [31:0] pre_pc;
    } fetch_data_t;

    localparam int FETCH_BUF_DEPTH = 8;

    typedef logic [$clog2(FETCH_BUF_DEPTH):0] fb_cnt_t;

    // Smaller of a requested transfer count and the number actually available.
    function automatic logic [1:0] clamp_cnt(input logic [1:0] req, input logic [1:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer handshake bundle: F2 entries in, decode entries out, consume
// count and occupancy. Master is the surrounding pipeline, slave the buffer.
interface fetch_buffer_if
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_data_t [1:0] in_data;
    logic              in_ready;
    fetch_data_t [1:0] out_data;
    logic [1:0]        out_cnt;
    logic [PTR_W:0]    count;

    modport master (
        output in_data,
        output out_cnt,
        input  in_ready,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_data,
        input  out_cnt,
        output in_ready,
        output out_data,
        output count
    );

endinterface

// File: rtl/fetch_buffer_ram.sv
// DEPTH x fetch_data_t register array with two write ports at consecutive
// addresses and two asynchronous read ports at consecutive addresses.
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [1:0]        wr_en,
    input  fetch_data_t [1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output fetch_data_t [1:0] rd_data
);
    logic [PTR_W-1:0] wr_addr_1;
    logic [PTR_W-1:0] rd_addr_1;
    fetch_data_t      mem_q [DEPTH];

    assign wr_addr_1 = wr_addr + PTR_W'(1);
    assign rd_addr_1 = rd_addr + PTR_W'(1);

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        fetch_data_t entry_reg;

        // Contents are don't-care after reset, so the array carries no reset.
        always_ff @(posedge clk) begin
            if (wr_en[0] && wr_addr == PTR_W'(gi)) begin
                entry_reg <= wr_data[0];
            end else if (wr_en[1] && wr_addr_1 == PTR_W'(gi)) begin
                entry_reg <= wr_data[1];
            end
        end

        assign mem_q[gi] = entry_reg;
    end

    assign rd_data[0] = mem_q[rd_addr];
    assign rd_data[1] = mem_q[rd_addr_1];

endmodule

// File: rtl/fetch_buffer.sv
// Dual-in/dual-out circular instruction queue between F2 and decode.
// Optional FETCH_BUF_BYPASS_EN forwards input straight to decode when empty.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_buffer_if.slave fb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              in_ready;
    logic              bypass;
    logic [1:0]        n_acc, n_vis, n_out, n_skip, n_wr, n_rd;
    fetch_data_t [1:0] cmp;
    fetch_data_t [1:0] wr_data;
    fetch_data_t [1:0] rd_data;
    logic [1:0]        wr_en;

    // Room is judged on the registered count, before any same-cycle dequeue.
    assign in_ready = ~reset & (count_reg <= ROOM_LIMIT);

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = in_ready && (count_reg == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        cmp     = '0;
        n_acc   = 2'd0;
        n_vis   = 2'd0;
        n_out   = 2'd0;
        n_skip  = 2'd0;
        n_wr    = 2'd0;
        n_rd    = 2'd0;
        wr_data = '0;
        wr_en   = 2'b00;

        // Compact valid inputs into program order: cmp[0] oldest.
        cmp[0] = fb.in_data[1].valid ? fb.in_data[1] : fb.in_data[0];
        cmp[1] = fb.in_data[0];
        if (in_ready) begin
            n_acc = 2'(fb.in_data[1].valid) + 2'(fb.in_data[0].valid);
        end

        if (bypass) begin
            n_vis = n_acc;
        end else begin
            n_vis = (count_reg >= CNT_W'(2)) ? 2'd2 : count_reg[1:0];
        end
        n_out = clamp_cnt(fb.out_cnt, n_vis);

        // Forwarded entries consumed this cycle never touch storage.
        n_skip = bypass ? n_out : 2'd0;
        n_rd   = bypass ? 2'd0 : n_out;
        n_wr   = n_acc - n_skip;

        wr_data[0] = (n_skip == 2'd0) ? cmp[0] : cmp[1];
        wr_data[1] = cmp[1];
        wr_en[0]   = !flush && (n_wr != 2'd0);
        wr_en[1]   = !flush && (n_wr == 2'd2);

        wr_ptr_next = wr_ptr_reg + PTR_W'(n_wr);
        rd_ptr_next = rd_ptr_reg + PTR_W'(n_rd);
        count_next  = count_reg + CNT_W'(n_wr) - CNT_W'(n_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr_reg),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // Output slot [1] shows the oldest visible entry, slot [0] the next one.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_slot
        localparam int VI = 1 - gi;
        assign fb.out_data[gi] = (n_vis > 2'(VI)) ? (bypass ? cmp[VI] : rd_data[VI]) : '0;
    end

    assign fb.in_ready = in_ready;
    assign fb.count    = count_reg;

    out_cnt_legal: assert property (@(posedge clk) disable iff (reset) fb.out_cnt <= n_vis);

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic
// against a queue-based model of the buffer (honours FETCH_BUF_BYPASS_EN).
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = FETCH_BUF_DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_data_t q[$];

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .fb    (bus)
    );

    always #5 clk = ~clk;

    function automatic fetch_data_t mk(input logic [31:0] pc, input logic pre_b);
        fetch_data_t e;
        e.valid  = 1'b1;
        e.pc     = pc;
        e.instr  = {pc[15:0], 16'h0013} ^ 32'h5a5a_0000;
        e.pre_b  = pre_b;
        e.pre_pc = pre_b ? pc + 32'h40 : 32'h0;
        return e;
    endfunction

    function automatic fetch_data_t mk_rand();
        fetch_data_t e;
        e.valid  = ($urandom_range(0, 3) != 0);
        e.pc     = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        e.instr  = $urandom;
        e.pre_b  = $urandom_range(0, 1) == 1;
        e.pre_pc = $urandom;
        return e;
    endfunction

    // One clock cycle: model computes expectations, DUT is driven, outputs checked.
    task automatic step(input fetch_data_t i1, input fetch_data_t i0, input int req,
                        input logic fl, input string tag);
        fetch_data_t acc[$];
        fetch_data_t vis[$];
        fetch_data_t e1, e0;
        logic        rdy;
        fb_cnt_t     ec;
        int          oc;

        rdy = (DEPTH - q.size()) >= 2;
        acc = {};
        if (rdy) begin
            if (i1.valid) acc.push_back(i1);
            if (i0.valid) acc.push_back(i0);
        end
        vis = q;
`ifdef FETCH_BUF_BYPASS_EN
        if (q.size() == 0) vis = acc;
`endif
        e1 = '0;
        e0 = '0;
        if (vis.size() >= 1) e1 = vis[0];
        if (vis.size() >= 2) e0 = vis[1];
        oc = (req > vis.size()) ? vis.size() : req;
        ec = fb_cnt_t'(q.size());

        @(negedge clk);
        bus.in_data[1] = i1;
        bus.in_data[0] = i0;
        bus.out_cnt    = 2'(oc);
        flush          = fl;
        #1;
        $display("%-8s cnt=%0d rdy=%b out1=%h/%b out0=%h/%b oc=%0d fl=%b", tag, bus.count,
                 bus.in_ready, bus.out_data[1].pc, bus.out_data[1].valid,
                 bus.out_data[0].pc, bus.out_data[0].valid, oc, fl);
        checks++;
        if (bus.in_ready !== rdy) begin
            errors++;
            $display("FAIL %s in_ready got %b exp %b", tag, bus.in_ready, rdy);
        end
        checks++;
        if (bus.count !== ec) begin
            errors++;
            $display("FAIL %s count got %0d exp %0d", tag, bus.count, ec);
        end
        checks++;
        if (bus.out_data[1] !== e1) begin
            errors++;
            $display("FAIL %s out1 got %h exp %h", tag, bus.out_data[1], e1);
        end
        checks++;
        if (bus.out_data[0] !== e0) begin
            errors++;
            $display("FAIL %s out0 got %h exp %h", tag, bus.out_data[0], e0);
        end

        if (fl) begin
            q.delete();
        end else begin
            foreach (acc[k]) q.push_back(acc[k]);
            repeat (oc) void'(q.pop_front());
        end
    endtask

    task automatic idle(input int req, input string tag);
        step('0, '0, req, 1'b0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.count !== '0) begin
            errors++;
            $display("FAIL %s count got %0d exp 0", tag, bus.count);
        end
        checks++;
        if (bus.out_data[1].valid !== 1'b0 || bus.out_data[0].valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out valid got %b%b exp 00", tag,
                     bus.out_data[1].valid, bus.out_data[0].valid);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready got %b exp 0", tag, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        step(mk(32'h10, 1'b0), mk(32'h14, 1'b0), 0, 1'b0, "rst_fill");
        step(mk(32'h18, 1'b1), mk(32'h1c, 1'b0), 0, 1'b0, "rst_fill");
        step('0, mk(32'h20, 1'b0), 0, 1'b0, "rst_fill");
        idle(0, "rst_five");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        idle(0, "rst_rel");
    endtask

    task automatic test_ordering();
        step('0, '0, 0, 1'b1, "ord_clr");
        step(mk(32'h100, 1'b1), mk(32'h104, 1'b0), 1, 1'b0, "ord");
        step(mk(32'h108, 1'b0), mk(32'h10c, 1'b0), 1, 1'b0, "ord");
        repeat (4) idle(1, "ord");
        idle(0, "ord_end");
    endtask

    task automatic test_partial();
        step('0, '0, 0, 1'b1, "part_clr");
        step('0, mk(32'h200, 1'b1), 0, 1'b0, "part");
        idle(0, "part_chk");
        idle(1, "part_pop");
        idle(0, "part_end");
    endtask

    task automatic test_full_wrap();
        step('0, '0, 0, 1'b1, "full_clr");
        for (int i = 0; i < 4; i++) begin
            step(mk(32'h500 + 32'(i * 8), 1'b0), mk(32'h504 + 32'(i * 8), 1'b1), 0, 1'b0, "fill");
        end
        step(mk(32'h5f0, 1'b0), mk(32'h5f4, 1'b0), 0, 1'b0, "drop");
        step(mk(32'h600, 1'b0), mk(32'h604, 1'b0), 2, 1'b0, "wrap");
        step(mk(32'h600, 1'b0), mk(32'h604, 1'b0), 2, 1'b0, "wrap");
        step(mk(32'h608, 1'b1), mk(32'h60c, 1'b0), 0, 1'b0, "wrap");
        repeat (5) idle(2, "drain");
    endtask

    task automatic test_simultaneous();
        step('0, '0, 0, 1'b1, "sim_clr");
        step(mk(32'h700, 1'b0), mk(32'h704, 1'b0), 0, 1'b0, "sim");
        step('0, mk(32'h708, 1'b0), 0, 1'b0, "sim");
        step(mk(32'h70c, 1'b1), mk(32'h710, 1'b0), 2, 1'b0, "sim");
        idle(0, "sim_chk");
    endtask

    task automatic test_flush();
        step('0, '0, 0, 1'b1, "fl_clr");
        for (int i = 0; i < 3; i++) begin
            step(mk(32'h800 + 32'(i * 8), 1'b0), mk(32'h804 + 32'(i * 8), 1'b0), 0, 1'b0, "fl_fill");
        end
        step(mk(32'h880, 1'b0), mk(32'h884, 1'b0), 2, 1'b1, "flush");
        step(mk(32'h300, 1'b1), mk(32'h304, 1'b0), 0, 1'b0, "fl_next");
        idle(0, "fl_end");
    endtask

    task automatic test_random();
        step('0, '0, 0, 1'b1, "rnd_clr");
        for (int i = 0; i < 300; i++) begin
            step(mk_rand(), mk_rand(), $urandom_range(0, 2), $urandom_range(0, 39) == 0, "rnd");
        end
        idle(0, "rnd_end");
    endtask

    initial begin
        bus.in_data = '0;
        bus.out_cnt = 2'd0;
        test_reset();
        test_ordering();
        test_partial();
        test_full_wrap();
        test_simultaneous();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
